// File: rtl/mcpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_mem_arbiter
// Brief    : Round-robin arbiter sharing the MCPU memory port between clients.
//            Define MCPU_MEM_ARB_PRIO_EN to give client 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_mem_arbiter #(
    parameter int NUM_CLIENTS = 3,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32
) (
    input  logic                                 clkrst_core_clk,
    input  logic                                 clkrst_core_rst_n,
    input  logic [NUM_CLIENTS-1:0]               req_valid,
    output logic [NUM_CLIENTS-1:0]               req_ready,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]        req_addr,
    input  logic [NUM_CLIENTS-1:0]               req_we,
    input  logic [NUM_CLIENTS*DATA_W-1:0]        req_wdata,
    input  logic [NUM_CLIENTS*(DATA_W/8)-1:0]    req_wmask,
    output logic [NUM_CLIENTS-1:0]               resp_valid,
    output logic [DATA_W-1:0]                    resp_rdata,
    output logic                                 mem_valid,
    input  logic                                 mem_ready,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic                                 mem_we,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic [DATA_W/8-1:0]                  mem_wmask,
    input  logic                                 mem_resp_valid,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic                                 busy,
    output logic                                 arb_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [PTR_W-1:0]       w_sel;
    logic                   w_any;
    logic [NUM_CLIENTS-1:0] w_ready;
    logic [NUM_CLIENTS-1:0] r_resp_valid;
    logic [DATA_W-1:0]      r_resp_rdata;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_we;
    logic [DATA_W-1:0]      r_wdata;
    logic [MASK_W-1:0]      r_wmask;
    logic                   r_arb_err;
    logic                   w_resp_done;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
        return PTR_W'(s);
    endfunction

    // Scan from the highest offset down so the nearest requester past rr_ptr wins.
    always_comb begin
        w_sel = r_rr_ptr;
        w_any = 1'b0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_sel = wrap_idx(r_rr_ptr, k);
                w_any = 1'b1;
            end
        end
`ifdef MCPU_MEM_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_sel = '0;
            w_any = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_ready[w_sel] = 1'b1;
                    w_state_next   = S_ISSUE;
                end
            end
            S_ISSUE: if (mem_ready)      w_state_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_resp_done = (r_state == S_WAIT) && mem_resp_valid;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_arb_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= '0;
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_sel;
                r_addr  <= req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                r_we    <= req_we[w_sel];
                r_wdata <= req_wdata[int'(w_sel)*DATA_W +: DATA_W];
                r_wmask <= req_wmask[int'(w_sel)*MASK_W +: MASK_W];
            end
            if (w_resp_done) begin
                r_resp_valid <= NUM_CLIENTS'(1) << r_grant;
                r_resp_rdata <= mem_rdata;
`ifdef MCPU_MEM_ARB_PRIO_EN
                if (r_grant != '0) r_rr_ptr <= wrap_idx(r_grant, 1);
`else
                r_rr_ptr <= wrap_idx(r_grant, 1);
`endif
            end
            if (mem_resp_valid && r_state != S_WAIT) r_arb_err <= 1'b1;
        end
    end

    // Gate with reset so no accept pulse can leak out while reset is held.
    assign req_ready  = w_ready & {NUM_CLIENTS{clkrst_core_rst_n}};
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_valid  = (r_state == S_ISSUE);
    assign mem_addr   = r_addr;
    assign mem_we     = r_we;
    assign mem_wdata  = r_wdata;
    assign mem_wmask  = r_wmask;
    assign busy       = (r_state != S_IDLE);
    assign arb_err    = r_arb_err;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_mem_arbiter
// Brief    : Directed scoreboard bench for mcpu_mem_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_we;
    logic [N*DW-1:0]   req_wdata;
    logic [N*MW-1:0]   req_wmask;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [MW-1:0]     mem_wmask;
    logic              mem_resp_valid;
    logic [DW-1:0]     mem_rdata;
    logic              busy;
    logic              arb_err;

    mcpu_mem_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_we            (req_we),
        .req_wdata         (req_wdata),
        .req_wmask         (req_wmask),
        .resp_valid        (resp_valid),
        .resp_rdata        (resp_rdata),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_addr          (mem_addr),
        .mem_we            (mem_we),
        .mem_wdata         (mem_wdata),
        .mem_wmask         (mem_wmask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_rdata         (mem_rdata),
        .busy              (busy),
        .arb_err           (arb_err)
    );

    typedef struct { int client; logic [DW-1:0] data; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; logic [MW-1:0] wmask; } iss_t;

    resp_t exp_resp[$];
    iss_t  exp_iss[$];
    int    grant_log[$];
    int    grant_cyc[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_txn    = 0;
    int stall_left;
    logic hold_resp;
    logic spurious;
    logic hs;
    logic [AW-1:0] hs_addr;
    logic m_busy;
    int   m_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return (a == 30'h3FF) ? 32'hDEADBEEF : (32'hA5A5_0000 ^ {2'b00, a});
    endfunction

    function automatic int model_sel(input logic [N-1:0] rv, input int ptr);
`ifdef MCPU_MEM_ARB_PRIO_EN
        if (rv[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (rv[i]) return i;
        end
        return -1;
    endfunction

    // Scoreboard: predicts grants, pushes expectations, pops on responses.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int sel;
        resp_t r;
        iss_t  s;
        if (!rst_n) begin
            exp_resp.delete();
            exp_iss.delete();
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            if (resp_valid != '0) begin
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", resp_valid, 0);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_valid", resp_valid, 3'b001 << r.client);
                    check("resp_rdata", resp_rdata, r.data);
                    m_busy = 1'b0;
`ifdef MCPU_MEM_ARB_PRIO_EN
                    if (r.client != 0) m_ptr = (r.client + 1) % N;
`else
                    m_ptr = (r.client + 1) % N;
`endif
                end
            end
            exp_ready = '0;
            sel = -1;
            if (!m_busy && req_valid != '0) begin
                sel = model_sel(req_valid, m_ptr);
                exp_ready[sel] = 1'b1;
            end
            if (req_valid != '0 || req_ready != '0) check("req_ready", req_ready, exp_ready);
            if (sel >= 0) begin
                m_busy  = 1'b1;
                r.client = sel;
                r.data   = mem_f(req_addr[sel*AW +: AW]);
                exp_resp.push_back(r);
                s.addr  = req_addr[sel*AW +: AW];
                s.we    = req_we[sel];
                s.wdata = req_wdata[sel*DW +: DW];
                s.wmask = req_wmask[sel*MW +: MW];
                exp_iss.push_back(s);
                grant_log.push_back(sel);
                grant_cyc.push_back(cyc);
            end
        end
    end

    // Memory model: ready after stall_left cycles, response one cycle after handshake.
    always @(negedge clk) begin
        iss_t s;
        if (!rst_n) begin
            hs             = 1'b0;
            mem_ready      = 1'b0;
            mem_resp_valid = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            if (hs && !hold_resp) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_f(hs_addr);
                hs             = 1'b0;
            end
            if (spurious) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'h0BAD_0BAD;
                spurious       = 1'b0;
            end
            if (mem_valid && !hs) begin
                if (stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                    hs        = 1'b1;
                    hs_addr   = mem_addr;
                    n_txn++;
                    if (exp_iss.size() == 0) begin
                        check("mem_unexpected", 1, 0);
                    end else begin
                        s = exp_iss.pop_front();
                        check("mem_fields", {mem_addr, mem_we, mem_wdata, mem_wmask},
                                            {s.addr, s.we, s.wdata, s.wmask});
                    end
                end
            end else begin
                mem_ready = 1'b0;
            end
        end
    end

    task automatic do_req(input int c, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        bit ok;
        req_addr[c*AW +: AW]  = a;
        req_we[c]             = we;
        req_wdata[c*DW +: DW] = wd;
        req_wmask[c*MW +: MW] = wm;
        req_valid[c]          = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[c]) ok = 1'b1;
        end
        if (!ok) check("grant_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[c] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (exp_resp.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi;
        int n0;
        bit ok;
        rst_n = 1'b0; req_valid = '1; req_addr = '0; req_we = '0;
        req_wdata = '0; req_wmask = '0; mem_rdata = '0;
        stall_left = 0; hold_resp = 1'b0; spurious = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_outputs", {mem_valid, busy, arb_err, resp_valid}, 0);
        check("rst_data", {mem_addr, mem_we, mem_wdata, mem_wmask, resp_rdata}, 0);
        req_valid = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 0);

        // Single read with minimum latency.
        req_addr[2*AW +: AW] = 30'h3FF;
        req_we[2] = 1'b0;
        req_valid[2] = 1'b1;
        @(negedge clk);
        check("rd_T_ready", req_ready, 3'b100);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        @(negedge clk);
        check("rd_T1_mem", {mem_valid, mem_addr, mem_we}, {1'b1, 30'h3FF, 1'b0});
        @(negedge clk);
        check("rd_T2_wait", {mem_valid, busy}, 2'b01);
        @(negedge clk);
        check("rd_T3_resp", {resp_valid, resp_rdata}, {3'b100, 32'hDEADBEEF});
        check("rd_T3_idle", busy, 0);
        wait_idle();

        // All clients requesting continuously.
        grant_log.delete();
        grant_cyc.delete();
        req_addr  = {30'h30, 30'h20, 30'h10};
        req_we    = 3'b010;
        req_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_wmask = {4'hF, 4'h5, 4'hF};
        req_valid = 3'b111;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (grant_log.size() >= 9) ok = 1'b1;
        end
        if (!ok) check("rr_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        for (int i = 0; i < 9 && i < grant_log.size(); i++) begin
`ifdef MCPU_MEM_ARB_PRIO_EN
            check("prio_order", grant_log[i], 0);
`else
            check("rr_order", grant_log[i], i % N);
`endif
            if (i > 0) check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
        end
        do_req(1, 30'h44, 1'b0, 32'h0, 4'h0);
        wait_idle();

        // Backpressure: five cycles of mem_ready low.
        n0 = n_txn;
        stall_left = 5;
        do_req(0, 30'h55, 1'b1, 32'h1234_5678, 4'b0011);
        hi = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_valid) begin
                hi++;
                check("bp_stable", {mem_addr, mem_wdata, mem_wmask},
                                   {30'h55, 32'h1234_5678, 4'b0011});
            end else if (hi > 0) begin
                break;
            end
        end
        check("bp_valid_cycles", hi, 6);
        wait_idle();
        check("bp_txn_count", n_txn - n0, 1);

        // Reset while waiting for the memory response.
        hold_resp = 1'b1;
        do_req(1, 30'h100, 1'b1, 32'hCAFE_F00D, 4'hF);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (busy && !mem_valid) ok = 1'b1;
        end
        check("mid_reached_wait", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {req_ready, resp_valid, mem_valid, busy, arb_err}, 0);
        check("mid_rst_data", {mem_addr, mem_we, mem_wdata, mem_wmask, resp_rdata}, 0);
        hold_resp = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("mid_no_resp", {resp_valid, busy}, 0);
        end
        check("mid_arb_err", arb_err, 0);

        // Spurious memory response while idle.
        @(posedge clk);
        #1 spurious = 1'b1;
        repeat (2) @(negedge clk);
        check("spur_err", {arb_err, resp_valid}, {1'b1, 3'b000});
        do_req(2, 30'h77, 1'b0, 32'h0, 4'h0);
        wait_idle();
        check("spur_sticky", arb_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
